// File: rtl/out_check_pkg.sv
`default_nettype none
// ============================================================================
// Module   : out_check_pkg
// Purpose  : Shared state encodings and helpers for the output-stream checker.
// Revision : 1.0 - initial release
// ============================================================================
package out_check_pkg;

    localparam logic [7:0] c_st_initial  = 8'd0;
    localparam logic [7:0] c_st_run      = 8'd1;
    localparam logic [7:0] c_st_drain    = 8'd2;
    localparam logic [7:0] c_st_finished = 8'd3;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with extra-bit pointers for full/empty detect.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + {{c_aw{1'b0}}, 1'b1};
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{c_aw{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
    end

    // Same index with differing wrap bits means the writer lapped the reader.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign head  = r_mem[r_rd_ptr[c_aw-1:0]];

endmodule
`default_nettype wire

// File: rtl/out_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : out_stream_checker
// Purpose  : Compares a DUT output stream against queued expected words.
// Revision : 1.0 - initial release
// ============================================================================
module out_stream_checker
    import out_check_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] obs_data,
    input  logic             obs_valid,
    output logic             obs_ready,
    input  logic [WIDTH-1:0] exp_data,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic             end_req,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [WIDTH-1:0] first_bad,
    output logic             error,
    output logic             timeout,
    output logic             finished
);

    localparam int              c_tmr_w   = $clog2(TIMEOUT + 1);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT - 1);
    localparam logic [31:0]     c_cnt_max = 32'((64'd1 << CNT_W) - 64'd1);

    logic [7:0]         r_state;
    logic [7:0]         w_state_next;
    logic [c_tmr_w-1:0] r_timer;
    logic [CNT_W-1:0]   r_match_count;
    logic [CNT_W-1:0]   r_mismatch_count;
    logic [WIDTH-1:0]   r_first_bad;
    logic               r_error;
    logic               r_timeout;

    logic               w_full;
    logic               w_empty;
    logic [WIDTH-1:0]   w_head;
    logic               w_active;
    logic               w_push;
    logic               w_pop;
    logic               w_stall;
    logic               w_expire;

    assign w_active  = (r_state == c_st_run) || (r_state == c_st_drain);
    assign exp_ready = (r_state == c_st_run) && !w_full;
    assign obs_ready = w_active && !w_empty;
    assign w_push    = exp_valid && exp_ready;
    assign w_pop     = obs_valid && obs_ready;
    assign w_stall   = w_active && !w_empty && !w_pop;
    assign w_expire  = w_stall && (r_timer == c_tmr_last);

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (exp_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_initial: w_state_next = c_st_run;
            c_st_run: begin
                // Expiry wins over a concurrent end request.
                if (w_expire)     w_state_next = c_st_finished;
                else if (end_req) w_state_next = c_st_drain;
            end
            c_st_drain: begin
                if (w_expire || w_empty) w_state_next = c_st_finished;
            end
            c_st_finished: w_state_next = c_st_finished;
            default:       w_state_next = c_st_initial;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= c_st_initial;
            r_timer          <= '0;
            r_match_count    <= '0;
            r_mismatch_count <= '0;
            r_first_bad      <= '0;
            r_error          <= 1'b0;
            r_timeout        <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_stall) r_timer <= r_timer + {{(c_tmr_w-1){1'b0}}, 1'b1};
            else         r_timer <= '0;

            if (r_state == c_st_initial) begin
                r_match_count    <= '0;
                r_mismatch_count <= '0;
                r_first_bad      <= '0;
                r_error          <= 1'b0;
                r_timeout        <= 1'b0;
            end else begin
                if (w_pop) begin
                    if (obs_data == w_head) begin
                        r_match_count <= CNT_W'(sat_inc(32'(r_match_count), c_cnt_max));
                    end else begin
                        r_mismatch_count <= CNT_W'(sat_inc(32'(r_mismatch_count), c_cnt_max));
                        if (!r_error) begin
                            r_error     <= 1'b1;
                            r_first_bad <= obs_data;
                        end
                    end
                end
                if (w_expire) r_timeout <= 1'b1;
            end
        end
    end

    assign match_count    = r_match_count;
    assign mismatch_count = r_mismatch_count;
    assign first_bad      = r_first_bad;
    assign error          = r_error;
    assign timeout        = r_timeout;
    assign finished       = (r_state == c_st_finished);

endmodule
`default_nettype wire

// File: tb/tb_out_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_out_stream_checker
// Purpose  : Self-checking bench: vector table, corner sequences, random model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_out_stream_checker;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] obs_data;
    logic             obs_valid;
    logic             obs_ready;
    logic [WIDTH-1:0] exp_data;
    logic             exp_valid;
    logic             exp_ready;
    logic             end_req;
    logic [CNT_W-1:0] match_count;
    logic [CNT_W-1:0] mismatch_count;
    logic [WIDTH-1:0] first_bad;
    logic             error;
    logic             timeout;
    logic             finished;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    out_stream_checker #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .obs_data       (obs_data),
        .obs_valid      (obs_valid),
        .obs_ready      (obs_ready),
        .exp_data       (exp_data),
        .exp_valid      (exp_valid),
        .exp_ready      (exp_ready),
        .end_req        (end_req),
        .match_count    (match_count),
        .mismatch_count (mismatch_count),
        .first_bad      (first_bad),
        .error          (error),
        .timeout        (timeout),
        .finished       (finished)
    );

    typedef struct packed {
        logic [31:0]       n;
        logic [3:0][31:0]  exp_w;
        logic [3:0][31:0]  obs_w;
        logic [31:0]       e_match;
        logic [31:0]       e_mis;
        logic [31:0]       e_err;
        logic [31:0]       e_fb;
    } vec_t;

    vec_t vecs [4];

    function automatic vec_t mk(input int n,
                                input logic [31:0] e0, e1, e2, e3,
                                input logic [31:0] o0, o1, o2, o3,
                                input int em, input int emm, input int eerr,
                                input logic [31:0] efb);
        vec_t v;
        v.n       = 32'(n);
        v.exp_w   = {e3, e2, e1, e0};
        v.obs_w   = {o3, o2, o1, o0};
        v.e_match = 32'(em);
        v.e_mis   = 32'(emm);
        v.e_err   = 32'(eerr);
        v.e_fb    = efb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        obs_valid = 1'b0;
        obs_data  = '0;
        exp_valid = 1'b0;
        exp_data  = '0;
        end_req   = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_obs_ready"}, 32'(obs_ready), 32'd0);
        check({tag, "_exp_ready"}, 32'(exp_ready), 32'd0);
        check({tag, "_match"},     32'(match_count), 32'd0);
        check({tag, "_mismatch"},  32'(mismatch_count), 32'd0);
        check({tag, "_first_bad"}, first_bad, 32'd0);
        check({tag, "_error"},     32'(error), 32'd0);
        check({tag, "_timeout"},   32'(timeout), 32'd0);
        check({tag, "_finished"},  32'(finished), 32'd0);
    endtask

    // Leaves the checker in RUN, #1 after a rising edge.
    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic push_word(input logic [31:0] d);
        int n;
        exp_valid = 1'b1;
        exp_data  = d;
        n = 0;
        while (!exp_ready && n < 20) begin
            step();
            n++;
        end
        if (!exp_ready) check("push_wait_timeout", 32'(exp_ready), 32'd1);
        else            step();
        exp_valid = 1'b0;
    endtask

    task automatic drive_obs(input logic [31:0] d, input logic ereq);
        int n;
        obs_valid = 1'b1;
        obs_data  = d;
        end_req   = ereq;
        n = 0;
        while (!obs_ready && n < 20) begin
            step();
            n++;
        end
        if (!obs_ready) check("obs_wait_timeout", 32'(obs_ready), 32'd1);
        else            step();
        obs_valid = 1'b0;
        end_req   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] q [$];
    logic [31:0] m_fb;
    logic [31:0] front;
    int          m_match, m_mis, m_err, stall, occ, lat, k;
    logic        pv, ov, do_pop, do_push;

    initial begin
        reset = 1'b0;
        idle_inputs();
        #3;
        check_zero("por");

        vecs[0] = mk(3, 1, 2, 3, 0,  1, 2, 3, 0,  3, 0, 0, 32'h0);
        vecs[1] = mk(2, 0, 2, 0, 0,  0, 5, 0, 0,  1, 1, 1, 32'h5);
        vecs[2] = mk(4, 7, 8, 9, 10, 7, 3, 9, 11, 2, 2, 1, 32'h3);
        vecs[3] = mk(2, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0, 0,
                        32'hFFFF_FFFF, 32'hDEAD_BEEF, 0, 0, 2, 0, 0, 32'h0);

        for (int i = 0; i < 4; i++) begin
            apply_reset();
            for (int j = 0; j < int'(vecs[i].n); j++) push_word(vecs[i].exp_w[j]);
            for (int j = 0; j < int'(vecs[i].n); j++)
                drive_obs(vecs[i].obs_w[j], j == int'(vecs[i].n) - 1);
            lat = 1;
            while (!finished && lat < 6) begin
                step();
                lat++;
            end
            check($sformatf("vec%0d_fin_lat", i), 32'(finished && lat <= 2), 32'd1);
            check($sformatf("vec%0d_match", i), 32'(match_count), vecs[i].e_match);
            check($sformatf("vec%0d_mismatch", i), 32'(mismatch_count), vecs[i].e_mis);
            check($sformatf("vec%0d_error", i), 32'(error), vecs[i].e_err);
            check($sformatf("vec%0d_first_bad", i), first_bad, vecs[i].e_fb);
        end

        // Full FIFO refuses a fifth word; concurrent push/pop keeps occupancy.
        apply_reset();
        for (int j = 0; j < 4; j++) push_word(32'h10 + 32'(j));
        check("full_exp_ready", 32'(exp_ready), 32'd0);
        exp_valid = 1'b1;
        exp_data  = 32'h99;
        step();
        check("full_fifth_refused", 32'(exp_ready), 32'd0);
        exp_valid = 1'b0;
        for (int j = 0; j < 4; j++) drive_obs(32'h10 + 32'(j), 1'b0);
        check("full_drained_exp_ready", 32'(exp_ready), 32'd1);
        check("full_drained_obs_ready", 32'(obs_ready), 32'd0);
        check("full_drained_match", 32'(match_count), 32'd4);
        push_word(32'hA1);
        exp_valid = 1'b1;
        exp_data  = 32'hB2;
        obs_valid = 1'b1;
        obs_data  = 32'hA1;
        step();
        idle_inputs();
        check("pushpop_obs_ready", 32'(obs_ready), 32'd1);
        drive_obs(32'hB2, 1'b0);
        check("pushpop_match", 32'(match_count), 32'd6);
        check("pushpop_empty", 32'(obs_ready), 32'd0);

        // Stall timeout exactly TIMEOUT edges after the push.
        apply_reset();
        push_word(32'hA);
        k = 0;
        while (!finished && k < 40) begin
            step();
            k++;
        end
        check("to_cycles", 32'(k), 32'(TIMEOUT));
        check("to_flag", 32'(timeout), 32'd1);
        check("to_match", 32'(match_count), 32'd0);
        check("to_mismatch", 32'(mismatch_count), 32'd0);
        check("to_obs_ready", 32'(obs_ready), 32'd0);
        check("to_exp_ready", 32'(exp_ready), 32'd0);

        // End request with two words pending; expected pushes ignored in DRAIN.
        apply_reset();
        push_word(32'h21);
        push_word(32'h22);
        end_req = 1'b1;
        step();
        end_req = 1'b0;
        check("drain_exp_ready", 32'(exp_ready), 32'd0);
        check("drain_obs_ready", 32'(obs_ready), 32'd1);
        exp_valid = 1'b1;
        exp_data  = 32'h77;
        drive_obs(32'h21, 1'b0);
        check("drain_mid_fin", 32'(finished), 32'd0);
        drive_obs(32'h22, 1'b0);
        check("drain_empty_fin", 32'(finished), 32'd0);
        step();
        exp_valid = 1'b0;
        check("drain_fin", 32'(finished), 32'd1);
        check("drain_match", 32'(match_count), 32'd2);
        check("drain_timeout", 32'(timeout), 32'd0);

        // Asynchronous reset mid-stream.
        apply_reset();
        push_word(32'h31);
        push_word(32'h32);
        push_word(32'h33);
        drive_obs(32'h31, 1'b0);
        drive_obs(32'h32, 1'b0);
        check("mid_match_pre", 32'(match_count), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check_zero("async");
        step();
        reset = 1'b1;
        check("initial_exp_ready", 32'(exp_ready), 32'd0);
        step();
        check("post_rst_exp_ready", 32'(exp_ready), 32'd1);
        check("post_rst_obs_ready", 32'(obs_ready), 32'd0);
        push_word(32'h41);
        drive_obs(32'h41, 1'b0);
        check("post_rst_match", 32'(match_count), 32'd1);
        check("post_rst_empty", 32'(obs_ready), 32'd0);

        // Random traffic against a queue model; long enough to saturate matches.
        apply_reset();
        q.delete();
        m_match = 0;
        m_mis   = 0;
        m_err   = 0;
        m_fb    = '0;
        stall   = 0;
        for (int c = 0; c < 900; c++) begin
            occ = q.size();
            pv  = ($urandom_range(1, 0) == 1);
            ov  = ($urandom_range(3, 0) != 0) || (occ > 0 && stall >= TIMEOUT - 3);
            exp_valid = pv;
            exp_data  = $urandom;
            obs_valid = ov;
            if (occ > 0 && $urandom_range(7, 0) != 0) obs_data = q[0];
            else                                      obs_data = $urandom;
            check("rnd_exp_ready", 32'(exp_ready), 32'(occ < DEPTH));
            check("rnd_obs_ready", 32'(obs_ready), 32'(occ > 0));
            do_pop  = ov && occ > 0;
            do_push = pv && occ < DEPTH;
            if (do_pop) begin
                front = q.pop_front();
                if (obs_data == front) begin
                    if (m_match < CNT_MAX) m_match++;
                end else begin
                    if (m_mis < CNT_MAX) m_mis++;
                    if (m_err == 0) begin
                        m_err = 1;
                        m_fb  = obs_data;
                    end
                end
            end
            if (occ > 0 && !do_pop) stall++;
            else                    stall = 0;
            if (do_push) q.push_back(exp_data);
            step();
            check("rnd_match", 32'(match_count), 32'(m_match));
            check("rnd_mismatch", 32'(mismatch_count), 32'(m_mis));
        end
        idle_inputs();
        check("rnd_match_saturated", 32'(match_count), 32'(CNT_MAX));
        check("rnd_error", 32'(error), 32'(m_err));
        check("rnd_first_bad", first_bad, m_fb);
        check("rnd_timeout", 32'(timeout), 32'd0);
        check("rnd_finished", 32'(finished), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
